// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: Moore/Mealy FSM plus the retired-instruction counter.
// Outputs are decoded combinationally from state and instruction fields, and are held at 0 while rst_n is low.
module multicycle_ctrl #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [5:0]   op,
  input  logic [5:0]   func,
  input  logic         zero,
  input  logic         mem_rdy,
  output logic         PCWr,
  output logic         IRWr,
  output logic         MemRd,
  output logic         MemWr,
  output logic         RegWr,
  output logic         RegDst,
  output logic         MemtoReg,
  output logic         ExtOp,
  output logic         AluSrcA,
  output logic [1:0]   PCSrc,
  output logic [1:0]   AluSrcB,
  output logic [2:0]   ALUctr,
  output logic [2:0]   state,
  output logic         illegal,
  output logic [n-1:0] instret
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  state_t         r_state;
  logic [n-1:0]   r_instret;

  logic           w_is_r, w_is_lw, w_is_sw, w_is_addiu, w_is_ori, w_is_beq, w_is_j;
  logic           w_func_ok, w_legal;
  logic [2:0]     w_func_alu;

  assign w_is_r     = (op == OP_RTYPE);
  assign w_is_j     = (op == OP_J);
  assign w_is_beq   = (op == OP_BEQ);
  assign w_is_addiu = (op == OP_ADDIU);
  assign w_is_ori   = (op == OP_ORI);
  assign w_is_lw    = (op == OP_LW);
  assign w_is_sw    = (op == OP_SW);

  always_comb begin
    w_func_ok  = 1'b1;
    w_func_alu = ALU_ADD;
    case (func)
      6'b100000: w_func_alu = ALU_ADD;
      6'b100010: w_func_alu = ALU_SUB;
      6'b100100: w_func_alu = ALU_AND;
      6'b100101: w_func_alu = ALU_OR;
      6'b101010: w_func_alu = ALU_SLT;
      default:   w_func_ok  = 1'b0;
    endcase
  end

  assign w_legal = (w_is_r & w_func_ok) | w_is_j | w_is_beq | w_is_addiu |
                   w_is_ori | w_is_lw | w_is_sw;

  // Every transition back to IF except the fetch stall retires an instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IF;
      r_instret <= '0;
    end else begin
      case (r_state)
        S_IF:  if (mem_rdy) r_state <= S_ID;
        S_ID: begin
          if (w_is_j) begin
            r_state   <= S_IF;
            r_instret <= r_instret + 1'b1;
          end else if (!w_legal) begin
            r_state <= S_ERR;
          end else begin
            r_state <= S_EX;
          end
        end
        S_EX: begin
          if (w_is_r | w_is_addiu | w_is_ori) begin
            r_state <= S_WB;
          end else if (w_is_lw | w_is_sw) begin
            r_state <= S_MEM;
          end else if (w_is_beq) begin
            r_state   <= S_IF;
            r_instret <= r_instret + 1'b1;
          end else begin
            r_state <= S_ERR;
          end
        end
        S_MEM: begin
          if (w_is_lw) begin
            if (mem_rdy) r_state <= S_WB;
          end else if (w_is_sw) begin
            if (mem_rdy) begin
              r_state   <= S_IF;
              r_instret <= r_instret + 1'b1;
            end
          end else begin
            r_state <= S_ERR;
          end
        end
        S_WB: begin
          r_state   <= S_IF;
          r_instret <= r_instret + 1'b1;
        end
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_ERR;
      endcase
    end
  end

  logic       w_pcwr, w_irwr, w_memrd, w_memwr, w_regwr, w_regdst, w_memtoreg, w_extop, w_asa;
  logic [1:0] w_pcsrc, w_asb;
  logic [2:0] w_alu;

  always_comb begin
    w_pcwr     = 1'b0;
    w_irwr     = 1'b0;
    w_memrd    = 1'b0;
    w_memwr    = 1'b0;
    w_regwr    = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_extop    = 1'b0;
    w_asa      = 1'b0;
    w_pcsrc    = 2'b00;
    w_asb      = 2'b00;
    w_alu      = ALU_ADD;
    case (r_state)
      S_IF: begin
        w_memrd = 1'b1;
        w_asb   = 2'b01;
        w_irwr  = mem_rdy;
        w_pcwr  = mem_rdy;
      end
      // Branch target is computed here so EX can load it from ALUOut.
      S_ID: begin
        w_asb   = 2'b11;
        w_extop = 1'b1;
        if (w_is_j) begin
          w_pcwr  = 1'b1;
          w_pcsrc = 2'b10;
        end
      end
      S_EX: begin
        w_asa = 1'b1;
        if (w_is_r) begin
          w_alu = w_func_alu;
        end else if (w_is_lw | w_is_sw | w_is_addiu) begin
          w_asb   = 2'b10;
          w_extop = 1'b1;
        end else if (w_is_ori) begin
          w_asb = 2'b10;
          w_alu = ALU_OR;
        end else if (w_is_beq) begin
          w_alu   = ALU_SUB;
          w_pcsrc = 2'b01;
          w_pcwr  = zero;
        end
      end
      S_MEM: begin
        w_memrd = w_is_lw;
        w_memwr = w_is_sw;
      end
      S_WB: begin
        w_regwr    = 1'b1;
        w_regdst   = w_is_r;
        w_memtoreg = w_is_lw;
      end
      default: ;
    endcase
  end

  assign PCWr     = rst_n & w_pcwr;
  assign IRWr     = rst_n & w_irwr;
  assign MemRd    = rst_n & w_memrd;
  assign MemWr    = rst_n & w_memwr;
  assign RegWr    = rst_n & w_regwr;
  assign RegDst   = rst_n & w_regdst;
  assign MemtoReg = rst_n & w_memtoreg;
  assign ExtOp    = rst_n & w_extop;
  assign AluSrcA  = rst_n & w_asa;
  assign PCSrc    = rst_n ? w_pcsrc : 2'b00;
  assign AluSrcB  = rst_n ? w_asb   : 2'b00;
  assign ALUctr   = rst_n ? w_alu   : 3'b000;
  assign state    = r_state;
  assign illegal  = rst_n & (r_state == S_ERR);
  assign instret  = r_instret;

endmodule
